// File: rtl/game_board_controller.sv
// Tic-tac-toe board controller: tracks X/O marks from single-cell mouse
// clicks, alternates movers, detects wins and ties, and drives screen
// selects plus one-cycle score pulses.
//
// state | meaning
// ------+--------------------------------------------------------------
// START | start screen; restart or a click begins a game (no mark placed)
// PLAY  | waiting for the current mover to click an empty cell
// CHECK | one cycle: evaluate the mover's lines, then win / tie / toggle
// WIN_X | X completed a line; board frozen until restart or click
// WIN_O | O completed a line; board frozen until restart or click
// TIE   | board full with no line; frozen until restart or click
module game_board_controller #(
    parameter bit FIRST_X = 1'b1
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic [8:0] clickedMatrix,
    input  logic       restart,
    input  logic       erase,
    output logic [8:0] x_matrix,
    output logic [8:0] o_matrix,
    output logic       turnoX,
    output logic       turnoO,
    output logic       displayStartPlaying,
    output logic       ganadorX,
    output logic       ganadorO,
    output logic       tie,
    output logic       inc_x_score,
    output logic       inc_o_score,
    output logic       resetScore
);

    typedef enum logic [2:0] {
        START = 3'd0,
        PLAY  = 3'd1,
        CHECK = 3'd2,
        WIN_X = 3'd3,
        WIN_O = 3'd4,
        TIE   = 3'd5
    } state_t;

    state_t     state;
    logic [8:0] prev_click;
    logic       erase_q;

    logic       click_onehot;
    logic       click_ok;
    logic       cell_free;
    logic       board_full;
    logic       mover_wins;
    logic       begin_game;
    logic [8:0] mover_matrix;

    function automatic logic has_line(input logic [8:0] m);
        return (m[0] & m[1] & m[2]) |
               (m[3] & m[4] & m[5]) |
               (m[6] & m[7] & m[8]) |
               (m[0] & m[3] & m[6]) |
               (m[1] & m[4] & m[7]) |
               (m[2] & m[5] & m[8]) |
               (m[0] & m[4] & m[8]) |
               (m[2] & m[4] & m[6]);
    endfunction

    // Click qualification, occupancy and win/tie evaluation for the FSM.
    always_comb begin
        click_onehot = (clickedMatrix != 9'h000) &&
                       ((clickedMatrix & (clickedMatrix - 9'd1)) == 9'h000);
        // A held button only counts on the cycle it first appears.
        click_ok     = click_onehot && (prev_click == 9'h000);
        cell_free    = ((clickedMatrix & (x_matrix | o_matrix)) == 9'h000);
        board_full   = ((x_matrix | o_matrix) == 9'h1FF);
        mover_matrix = turnoX ? x_matrix : o_matrix;
        mover_wins   = has_line(mover_matrix);
        begin_game   = 1'b0;
        case (state)
            START, WIN_X, WIN_O, TIE: begin_game = restart || click_ok;
            PLAY, CHECK:              begin_game = restart;
            default:                  begin_game = 1'b0;
        endcase
    end

    // Edge-detect history; updates every cycle regardless of state.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            prev_click <= 9'h000;
            erase_q    <= 1'b0;
        end else begin
            prev_click <= clickedMatrix;
            erase_q    <= erase;
        end
    end

    // Game FSM with registered board, turn, screen and pulse outputs.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            state               <= START;
            x_matrix            <= 9'h000;
            o_matrix            <= 9'h000;
            turnoX              <= 1'b0;
            turnoO              <= 1'b0;
            displayStartPlaying <= 1'b1;
            ganadorX            <= 1'b0;
            ganadorO            <= 1'b0;
            tie                 <= 1'b0;
            inc_x_score         <= 1'b0;
            inc_o_score         <= 1'b0;
            resetScore          <= 1'b0;
        end else begin
            inc_x_score <= 1'b0;
            inc_o_score <= 1'b0;
            resetScore  <= 1'b0;
            if (erase) begin
                state               <= START;
                x_matrix            <= 9'h000;
                o_matrix            <= 9'h000;
                turnoX              <= 1'b0;
                turnoO              <= 1'b0;
                displayStartPlaying <= 1'b1;
                ganadorX            <= 1'b0;
                ganadorO            <= 1'b0;
                tie                 <= 1'b0;
                // A held erase keeps the board clear but clears scores once.
                resetScore          <= ~erase_q;
            end else if (begin_game) begin
                state               <= PLAY;
                x_matrix            <= 9'h000;
                o_matrix            <= 9'h000;
                turnoX              <= FIRST_X;
                turnoO              <= ~FIRST_X;
                displayStartPlaying <= 1'b1;
                ganadorX            <= 1'b0;
                ganadorO            <= 1'b0;
                tie                 <= 1'b0;
            end else begin
                case (state)
                    START: begin
                        displayStartPlaying <= 1'b1;
                    end
                    PLAY: begin
                        if (click_ok && cell_free) begin
                            if (turnoX) begin
                                x_matrix <= x_matrix | clickedMatrix;
                            end else begin
                                o_matrix <= o_matrix | clickedMatrix;
                            end
                            state <= CHECK;
                        end
                    end
                    CHECK: begin
                        if (mover_wins) begin
                            if (turnoX) begin
                                state       <= WIN_X;
                                ganadorX    <= 1'b1;
                                inc_x_score <= 1'b1;
                            end else begin
                                state       <= WIN_O;
                                ganadorO    <= 1'b1;
                                inc_o_score <= 1'b1;
                            end
                            turnoX              <= 1'b0;
                            turnoO              <= 1'b0;
                            displayStartPlaying <= 1'b0;
                        end else if (board_full) begin
                            state               <= TIE;
                            tie                 <= 1'b1;
                            turnoX              <= 1'b0;
                            turnoO              <= 1'b0;
                            displayStartPlaying <= 1'b0;
                        end else begin
                            turnoX <= ~turnoX;
                            turnoO <= ~turnoO;
                            state  <= PLAY;
                        end
                    end
                    WIN_X, WIN_O, TIE: begin
                        state <= state;
                    end
                    default: begin
                        state               <= START;
                        x_matrix            <= 9'h000;
                        o_matrix            <= 9'h000;
                        turnoX              <= 1'b0;
                        turnoO              <= 1'b0;
                        displayStartPlaying <= 1'b1;
                        ganadorX            <= 1'b0;
                        ganadorO            <= 1'b0;
                        tie                 <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
